// File: rtl/spi_flash_read_cache_if.sv
// Bus bundle between the 6809 flash window, the read cache and the
// downstream SPI read engine. The cache sits on the slave side.
interface spi_flash_read_cache_if;
    logic        i_CE;
    logic [15:0] i_ADDRESS_BUS;
    logic        i_RW;
    logic        i_FLUSH;
    logic [7:0]  o_DATA;
    logic        o_MemoryReady;
    logic        o_FLASH_REQ;
    logic [11:0] o_FLASH_ADDR;
    logic [7:0]  i_FLASH_DATA;
    logic        i_FLASH_DONE;
    logic        o_ERROR;

    modport slave (
        input  i_CE, i_ADDRESS_BUS, i_RW, i_FLUSH, i_FLASH_DATA, i_FLASH_DONE,
        output o_DATA, o_MemoryReady, o_FLASH_REQ, o_FLASH_ADDR, o_ERROR
    );

    modport master (
        output i_CE, i_ADDRESS_BUS, i_RW, i_FLUSH, i_FLASH_DATA, i_FLASH_DONE,
        input  o_DATA, o_MemoryReady, o_FLASH_REQ, o_FLASH_ADDR, o_ERROR
    );
endinterface

// File: rtl/spi_flash_read_cache.sv
// Direct-mapped 16-byte read cache in front of the SPI flash read engine.
// Hits answer in one clock; misses stretch the 6809 with MRDY until the
// engine returns the byte or the 256-cycle fill timeout expires.
//
// state | meaning
// IDLE  | waiting for a read strobe in the flash window
// WAIT  | miss outstanding, MRDY low, request held to the SPI engine
// HOLD  | data presented, waiting for the CPU to drop i_CE
module spi_flash_read_cache (
    input  logic                         clk,
    input  logic                         reset,
    spi_flash_read_cache_if.slave        bus
);
    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t      state_q, state_d;
    logic [15:0] valid_q, valid_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  data_q, data_d;
    logic        mrdy_q, mrdy_d;
    logic        req_q, req_d;
    logic [11:0] faddr_q, faddr_d;
    logic        err_q, err_d;
    logic        fill_we;

    // Tag and data arrays are not reset; the valid bits alone gate their use.
    logic [7:0]  cache_data_q [16];
    logic [7:0]  cache_tag_q  [16];

    logic [3:0]  idx;
    logic [7:0]  tag;
    logic        hit;
    logic        unused_addr_hi;

    assign idx            = bus.i_ADDRESS_BUS[3:0];
    assign tag            = bus.i_ADDRESS_BUS[11:4];
    assign unused_addr_hi = ^bus.i_ADDRESS_BUS[15:12];
    // A flush on the same edge as an access start must force a miss.
    assign hit            = valid_q[idx] && (cache_tag_q[idx] == tag) && !bus.i_FLUSH;

    // Next-state and registered-output logic for the access sequencer.
    always_comb begin
        state_d = state_q;
        valid_d = bus.i_FLUSH ? 16'h0000 : valid_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        mrdy_d  = mrdy_q;
        req_d   = req_q;
        faddr_d = faddr_q;
        err_d   = 1'b0;
        fill_we = 1'b0;
        case (state_q)
            IDLE: begin
                mrdy_d = 1'b1;
                if (bus.i_CE && bus.i_RW) begin
                    if (hit) begin
                        data_d  = cache_data_q[idx];
                        state_d = HOLD;
                    end else begin
                        mrdy_d  = 1'b0;
                        req_d   = 1'b1;
                        faddr_d = bus.i_ADDRESS_BUS[11:0];
                        cnt_d   = 8'h00;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (bus.i_FLASH_DONE) begin
                    // Fill is applied after the flush clear so it wins for its index.
                    fill_we               = 1'b1;
                    valid_d[faddr_q[3:0]] = 1'b1;
                    data_d                = bus.i_FLASH_DATA;
                    req_d                 = 1'b0;
                    mrdy_d                = 1'b1;
                    state_d               = HOLD;
                end else if (cnt_q == 8'hFF) begin
                    req_d   = 1'b0;
                    data_d  = 8'hFF;
                    mrdy_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + 8'h01;
                end
            end
            HOLD: begin
                mrdy_d = 1'b1;
                if (!bus.i_CE) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            valid_q <= 16'h0000;
            cnt_q   <= 8'h00;
            data_q  <= 8'h00;
            mrdy_q  <= 1'b1;
            req_q   <= 1'b0;
            faddr_q <= 12'h000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            mrdy_q  <= mrdy_d;
            req_q   <= req_d;
            faddr_q <= faddr_d;
            err_q   <= err_d;
        end
    end

    // Cache array write on fill completion; a done coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (reset && fill_we) begin
            cache_data_q[faddr_q[3:0]] <= bus.i_FLASH_DATA;
            cache_tag_q[faddr_q[3:0]]  <= faddr_q[11:4];
        end
    end

    assign bus.o_DATA        = data_q;
    assign bus.o_MemoryReady = mrdy_q;
    assign bus.o_FLASH_REQ   = req_q;
    assign bus.o_FLASH_ADDR  = faddr_q;
    assign bus.o_ERROR       = err_q;
endmodule

// File: doc/spi_flash_read_cache.md
SPI_FLASH_READ_CACHE -- requirements
Module: spi_flash_read_cache

Interface
REQ-001 SHALL have no parameters; geometry is fixed at 16 direct-mapped byte entries, index addr[3:0], tag addr[11:4], 1 valid bit per entry.
REQ-002 SHALL provide the following ports (clock and reset first):
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-low reset.
- i_CE  input  1  decoded flash-window select from the address decoder, active high.
- i_ADDRESS_BUS  input  16  6809 address; only bits [11:0] are used.
- i_RW  input  1  6809 R/W; 1 = read.
- i_FLUSH  input  1  one-cycle pulse that invalidates all entries.
- o_DATA  output  8  read data to 6809, registered.
- o_MemoryReady  output  1  MRDY to 6809; 0 = stretch cycle, registered.
- o_FLASH_REQ  output  1  request to the downstream SPI read engine, level, registered.
- o_FLASH_ADDR  output  12  byte address for the downstream engine, registered, stable while o_FLASH_REQ = 1.
- i_FLASH_DATA  input  8  byte from the downstream engine, valid when i_FLASH_DONE = 1.
- i_FLASH_DONE  input  1  one-cycle completion pulse from the downstream engine.
- o_ERROR  output  1  one-cycle pulse on fill timeout.

Function
REQ-003 SHALL implement FSM states IDLE, WAIT, HOLD.
REQ-004 An access starts in IDLE on a clock edge where i_CE=1 and i_RW=1.
REQ-005 Hit (entry valid and tag equal, compared combinationally on the current address): SHALL load o_DATA with the cached byte on the same edge, keep o_MemoryReady=1, and go to HOLD; hit latency is 1 clk.
REQ-006 Miss: SHALL drive o_MemoryReady<=0, o_FLASH_REQ<=1, and o_FLASH_ADDR<=i_ADDRESS_BUS[11:0], clear the timeout counter, and go to WAIT, all on the same edge.
REQ-007 WAIT: SHALL hold o_FLASH_REQ and o_FLASH_ADDR constant until i_FLASH_DONE=1.
REQ-008 WAIT completion: on i_FLASH_DONE=1, SHALL write i_FLASH_DATA into the indexed entry, set tag and valid, load o_DATA<=i_FLASH_DATA, drive o_FLASH_REQ<=0 and o_MemoryReady<=1, and go to HOLD.
REQ-009 WAIT timeout: SHALL increment an 8-bit counter each WAIT cycle without done; when the counter reaches 255 with no done, SHALL drive o_FLASH_REQ<=0, o_DATA<=8'hFF, o_MemoryReady<=1, pulse o_ERROR for 1 clk, and go to HOLD without writing the cache.
REQ-010 i_FLASH_DONE arriving outside WAIT SHALL be ignored; it causes no cache write and no o_DATA change.
REQ-011 HOLD: SHALL stay in HOLD while i_CE=1, keeping o_DATA stable and o_MemoryReady=1; SHALL go to IDLE on the first edge with i_CE=0. A new access therefore requires i_CE to deassert first.
REQ-012 Writes: i_CE=1 with i_RW=0 SHALL leave the FSM in IDLE with o_MemoryReady=1 and no cache change; the flash window is read-only.
REQ-013 i_FLUSH SHALL clear all valid bits on the edge it is sampled, in any state.
REQ-014 i_FLUSH coinciding with an access start in IDLE SHALL force a miss.
REQ-015 i_FLUSH coinciding with a fill in WAIT: the fill write SHALL win for its index (that entry ends valid); all other entries SHALL be cleared.
REQ-016 i_FLUSH during WAIT without done SHALL NOT abort the outstanding fill.
REQ-017 i_ADDRESS_BUS[15:12] SHALL NOT affect the index, the tag, or o_FLASH_ADDR.
REQ-018 o_ERROR SHALL be 0 except for the single timeout cycle.

Reset
REQ-019 reset=0 on an edge SHALL force the FSM to IDLE, clear all valid bits and the timeout counter, and drive o_DATA=8'h00, o_MemoryReady=1, o_FLASH_REQ=0, o_FLASH_ADDR=12'h000, and o_ERROR=0.
REQ-020 Reset during WAIT SHALL drop o_FLASH_REQ on that edge and discard any i_FLASH_DONE arriving in the same cycle.
REQ-021 Tag and data storage SHALL NOT be cleared by reset; only the valid bits are cleared.

Verification
REQ-022 Cold miss then hit: read 0x1234, downstream returns 0xA5 after 20 clk -> o_MemoryReady low for 21 clk and o_FLASH_ADDR=0x234; o_DATA=0xA5. Deassert i_CE, then read 0xF234 -> hit, o_DATA=0xA5, o_MemoryReady never low, no o_FLASH_REQ.
REQ-023 Conflict eviction: fill 0x005 (0x11), then read 0x015 -> miss, fill 0x22. Re-read 0x005 -> miss again, o_FLASH_ADDR=0x005.
REQ-024 Timeout: read 0x100 with no i_FLASH_DONE -> after 256 WAIT cycles, o_ERROR pulses once, o_DATA=0xFF, o_MemoryReady=1. A re-read of 0x100 misses.
REQ-025 Flush races: fill entries 0x000 to 0x00F. Assert i_FLUSH in the same cycle as the i_FLASH_DONE of a fill to 0x020 -> 0x020 hits afterwards; 0x001 misses.
REQ-026 Reset mid-fill: assert reset=0 in WAIT with i_FLASH_DONE simultaneous -> o_FLASH_REQ=0, o_MemoryReady=1, o_DATA=0x00. The next read of the same address misses.
REQ-027 Write ignored: i_CE=1, i_RW=0 at 0x010 for 5 clk -> o_MemoryReady=1, no o_FLASH_REQ, cache contents unchanged.
